// File: rtl/alu_muldiv_seq.sv
// Iterative 32-bit multiply/divide sequencer that drives the shared execute-stage ALU as its datapath.
// Optional signed operation is enabled with `define MULDIV_SIGNED_EN (adds port sgn and a FIN state).
module alu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULDIV_SIGNED_EN
  input  logic             sgn,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero
);

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_PASS = 3'b111;

  // IDLE wait | MUL_STEP shift-add | DIV_CMP shift+compare | DIV_SUB restore | FIN sign fix | DONE result pulse
  typedef enum logic [2:0] {
    S_IDLE, S_MUL_STEP, S_DIV_CMP, S_DIV_SUB, S_FIN, S_DONE
  } state_t;

`ifdef MULDIV_SIGNED_EN
  localparam state_t S_END = S_FIN;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH-1:0] acc, mq;
  logic [CNT_W-1:0] cnt;
  logic             ge_r;

  logic             accept, last, carry, div0;
  logic [WIDTH-1:0] rem_sh, rem_nx;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             unused_alu_zero;

  assign unused_alu_zero = alu_zero;
  assign div0 = op && (b == '0);
  assign last = (cnt == CNT_W'(WIDTH - 1));
  assign rem_sh = {acc[WIDTH-2:0], mq[WIDTH-1]};
  assign rem_nx = ge_r ? alu_out : acc;

`ifdef MULDIV_SIGNED_EN
  logic op_r, neg_q, neg_r;
  assign a_mag = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag = (sgn && b[WIDTH-1]) ? -b : b;
`else
  assign a_mag = a;
  assign b_mag = b;
`endif

  always_comb begin
    state_nx    = state;
    accept      = 1'b0;
    carry       = 1'b0;
    alu_in1     = '0;
    alu_in2     = '0;
    alu_control = ALU_PASS;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        if (start) begin
          accept = 1'b1;
          if (div0)    state_nx = S_DONE;
          else if (op) state_nx = S_DIV_CMP;
          else         state_nx = S_MUL_STEP;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_MUL_STEP: begin
        busy        = 1'b1;
        alu_control = ALU_ADD;
        alu_in1     = acc;
        alu_in2     = mq[0] ? a_r : '0;
        carry       = (alu_out < acc);
        if (last) state_nx = S_END;
      end
      S_DIV_CMP: begin
        busy        = 1'b1;
        alu_control = ALU_SLT;
        alu_in1     = rem_sh;
        alu_in2     = b_r;
        state_nx    = S_DIV_SUB;
      end
      S_DIV_SUB: begin
        busy        = 1'b1;
        alu_control = ge_r ? ALU_SUB : ALU_PASS;
        alu_in1     = acc;
        alu_in2     = b_r;
        state_nx    = last ? S_END : S_DIV_CMP;
      end
      S_FIN: begin
        busy     = 1'b1;
        state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      a_r         <= '0;
      b_r         <= '0;
      acc         <= '0;
      mq          <= '0;
      cnt         <= '0;
      ge_r        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      op_r        <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            a_r         <= a_mag;
            b_r         <= b_mag;
            acc         <= '0;
            mq          <= op ? a_mag : b_mag;
            cnt         <= '0;
            ge_r        <= 1'b0;
            div_by_zero <= div0;
            // divide-by-zero finishes immediately with dividend in hi
            hi          <= div0 ? a : '0;
            lo          <= div0 ? '1 : '0;
`ifdef MULDIV_SIGNED_EN
            op_r        <= op;
            neg_q       <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r       <= sgn && a[WIDTH-1];
`endif
          end
        end
        S_MUL_STEP: begin
          acc <= {carry, alu_out[WIDTH-1:1]};
          mq  <= {alu_out[0], mq[WIDTH-1:1]};
          if (last) begin
            hi <= {carry, alu_out[WIDTH-1:1]};
            lo <= {alu_out[0], mq[WIDTH-1:1]};
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DIV_CMP: begin
          acc  <= rem_sh;
          mq   <= {mq[WIDTH-2:0], 1'b0};
          ge_r <= acc[WIDTH-1] | ~alu_out[0];
        end
        S_DIV_SUB: begin
          acc   <= rem_nx;
          mq[0] <= ge_r;
          if (last) begin
            hi <= rem_nx;
            lo <= {mq[WIDTH-1:1], ge_r};
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`ifdef MULDIV_SIGNED_EN
        S_FIN: begin
          if (op_r) begin
            if (neg_q) lo <= -lo;
            if (neg_r) hi <= -hi;
          end else if (neg_q) begin
            {hi, lo} <= -{hi, lo};
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq: directed vectors, behavioural ALU, monitor on done.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset, start, op, sgn;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo, alu_in1, alu_in2, alu_out;
  logic [2:0]  alu_control;
  logic        alu_zero;

`ifdef MULDIV_SIGNED_EN
  localparam int XTRA = 1;
`else
  localparam int XTRA = 0;
`endif
  localparam int MUL_LAT = 33 + XTRA;
  localparam int DIV_LAT = 65 + XTRA;

  always #5 clk = ~clk;

  alu_muldiv_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
`ifdef MULDIV_SIGNED_EN
    .sgn(sgn),
`endif
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
    .alu_out(alu_out), .alu_zero(alu_zero)
  );

  function automatic logic [31:0] alu_f(input logic [31:0] x, input logic [31:0] y,
                                        input logic [2:0] c);
    case (c)
      3'b000:  return x + y;
      3'b001:  return x - y;
      3'b110:  return {31'b0, (x < y)};
      3'b111:  return x;
      default: return 32'h0;
    endcase
  endfunction

  assign alu_out  = alu_f(alu_in1, alu_in2, alu_control);
  assign alu_zero = (alu_out == 32'h0);

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   bcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // monitor: ALU idle drive when not busy, and scoreboard pop on every done
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      bcnt = 0;
    end else begin
      if (!busy) begin
        chk("alu_idle_ctl", {61'b0, alu_control}, 64'd7);
        chk("alu_idle_in", {alu_in1, alu_in2}, 64'd0);
      end
      if (busy) bcnt++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("hi", {32'b0, hi}, {32'b0, e.hi});
          chk("lo", {32'b0, lo}, {32'b0, e.lo});
          chk("div_by_zero", {63'b0, div_by_zero}, {63'b0, e.dbz});
          chk("latency", 64'(cyc - e.t0 + 1), 64'(e.lat));
          chk("busy_cycles", 64'(bcnt), 64'(e.lat - 1));
          chk("busy_in_done", {63'b0, busy}, 64'd0);
        end
        bcnt = 0;
      end
    end
  end

  // called at a negedge; start is sampled by the following posedge
  task automatic drive(input logic o, input logic [31:0] ia, input logic [31:0] ib,
                       input logic s, input logic [31:0] eh, input logic [31:0] el,
                       input logic ed, input int lat, input int hold);
    exp_t e;
    op = o; a = ia; b = ib; sgn = s; start = 1'b1;
    @(posedge clk);
    #1;
    e.hi = eh; e.lo = el; e.dbz = ed; e.lat = lat; e.t0 = cyc;
    sb.push_back(e);
    if (hold == 0) start = 1'b0;
    @(negedge clk);
    chk("hi_at_start", {32'b0, hi}, {32'b0, (ed ? ia : 32'h0)});
    chk("busy_cycle1", {63'b0, busy}, {63'b0, ~ed});
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, {63'b0, busy}, 64'd0);
    chk({tag, "_done"}, {63'b0, done}, 64'd0);
    chk({tag, "_dbz"}, {63'b0, div_by_zero}, 64'd0);
    chk({tag, "_hilo"}, {hi, lo}, 64'd0);
    chk({tag, "_alu_in"}, {alu_in1, alu_in2}, 64'd0);
    chk({tag, "_alu_ctl"}, {61'b0, alu_control}, 64'd7);
  endtask

  initial begin
    int k;
    reset = 1'b1; start = 1'b0; op = 1'b0; sgn = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    // multiply
    drive(1'b0, 32'd7, 32'd6, 1'b0, 32'h0, 32'd42, 1'b0, MUL_LAT, 0);                  wait_done();
    drive(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h1, 1'b0, MUL_LAT, 0); wait_done();
    drive(1'b0, 32'h00010000, 32'h00010000, 1'b0, 32'h1, 32'h0, 1'b0, MUL_LAT, 0);       wait_done();
    drive(1'b0, 32'hFFFFFFFF, 32'd2, 1'b0, 32'h1, 32'hFFFFFFFE, 1'b0, MUL_LAT, 0);       wait_done();
    drive(1'b0, 32'h0, 32'd12345, 1'b0, 32'h0, 32'h0, 1'b0, MUL_LAT, 0);                 wait_done();

    // divide
    drive(1'b1, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0, DIV_LAT, 0);                  wait_done();
    drive(1'b1, 32'h80000001, 32'hFFFFFFFF, 1'b0, 32'h80000001, 32'h0, 1'b0, DIV_LAT, 0); wait_done();
    drive(1'b1, 32'hFFFFFFFF, 32'd1, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b0, DIV_LAT, 0);       wait_done();
    drive(1'b1, 32'd7, 32'd100, 1'b0, 32'd7, 32'h0, 1'b0, DIV_LAT, 0);                   wait_done();
    drive(1'b1, 32'hFFFFFFFF, 32'd10, 1'b0, 32'd5, 32'h19999999, 1'b0, DIV_LAT, 0);      wait_done();

    // divide by zero
    drive(1'b1, 32'd5, 32'd0, 1'b0, 32'd5, 32'hFFFFFFFF, 1'b1, 1, 0);                    wait_done();
    drive(1'b1, 32'd0, 32'd0, 1'b0, 32'd0, 32'hFFFFFFFF, 1'b1, 1, 0);                    wait_done();

    // back-to-back: next start presented while DONE is showing
    drive(1'b0, 32'd7, 32'd6, 1'b0, 32'h0, 32'd42, 1'b0, MUL_LAT, 0);
    k = 0;
    while (!done && k < 100) begin @(negedge clk); k++; end
    chk("b2b_done_seen", {63'b0, done}, 64'd1);
    drive(1'b1, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0, DIV_LAT, 0);
    wait_done();

    // reset mid-multiply with start held high while busy
    op = 1'b0; a = 32'd9; b = 32'd9; sgn = 1'b0; start = 1'b1;
    @(posedge clk);
    repeat (9) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("abort");
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_no_done_busy", {62'b0, busy, done}, 64'd0);

    // start held high for many busy cycles: only one operation results
    drive(1'b0, 32'd11, 32'd13, 1'b0, 32'h0, 32'd143, 1'b0, MUL_LAT, 15);                wait_done();
    drive(1'b1, 32'd143, 32'd13, 1'b0, 32'h0, 32'd11, 1'b0, DIV_LAT, 20);                wait_done();

`ifdef MULDIV_SIGNED_EN
    drive(1'b0, 32'hFFFFFFFA, 32'd7, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, MUL_LAT, 0); wait_done();
    drive(1'b1, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, DIV_LAT, 0); wait_done();
    drive(1'b1, 32'd7, 32'hFFFFFFFE, 1'b1, 32'd1, 32'hFFFFFFFD, 1'b0, DIV_LAT, 0);        wait_done();
    drive(1'b1, 32'hFFFFFFF9, 32'd0, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1, 0);       wait_done();
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
